// File: rtl/tt_pingpong_rd_ctrl_pkg.sv
// Shared definitions for the ping-pong read controller: bank states, read FSM
// states and the read-latency/credit constants.
package tt_pingpong_rd_ctrl_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY = 2'd0,
    BANK_FULL  = 2'd1,
    BANK_DRAIN = 2'd2
  } bank_state_t;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_DRAIN = 1'b1
  } rd_fsm_t;

  localparam int PP_NBANK = 2;
  localparam int RD_LAT   = 1;
  // One read in flight per cycle of SRAM latency plus one word being consumed.
  localparam logic [1:0] CREDIT_MAX = 2'(RD_LAT + 1);

endpackage

// File: rtl/tt_pp_out_fifo.sv
// Two-entry output FIFO holding a DATA_W payload plus its end-of-bank tag.
module tt_pp_out_fifo #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  input  logic              pop,
  output logic [1:0]        count,
  output logic              vld,
  output logic [DATA_W-1:0] head_data,
  output logic              head_last
);

  logic [DATA_W:0] mem [2];
  logic            wptr;
  logic            rptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
    end else begin
      if (push) wptr <= ~wptr;
      if (pop)  rptr <= ~rptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {push_last, push_data};
  end

  assign vld       = (count != 2'd0);
  assign head_data = mem[rptr][DATA_W-1:0];
  assign head_last = mem[rptr][DATA_W];

endmodule

// File: rtl/tt_pingpong_rd_ctrl.sv
// Ping-pong bank bookkeeping and credit-based linear drain to a valid/ready stream.
// Optional sticky overflow detection is enabled with TT_PP_OVF_CHECK_EN.
module tt_pingpong_rd_ctrl
  import tt_pingpong_rd_ctrl_pkg::*;
#(
  parameter int MEM_DEPTH  = 16,
  parameter int log2_DEPTH = 4,
  parameter int DATA_W     = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_done,
  output logic                  wr_bank,
  output logic                  wr_rdy,
  input  logic [log2_DEPTH-1:0] num_of_dat,
  output logic                  mem_rd_en,
  output logic                  mem_rbank,
  output logic [log2_DEPTH-1:0] mem_raddr,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  ovf_err
);

  localparam logic [log2_DEPTH-1:0] ADDR_MAX = log2_DEPTH'(MEM_DEPTH - 1);

  bank_state_t           bank_st [PP_NBANK];
  rd_fsm_t               rd_st;
  logic                  rd_bank;
  logic [log2_DEPTH-1:0] rd_addr_p0;
  logic [log2_DEPTH-1:0] len_p0;
  logic                  issue_done_p0;
  logic                  issue_p0;
  logic                  vld_p1;
  logic                  last_p1;
  logic [1:0]            fifo_cnt;
  logic                  fifo_vld;
  logic [DATA_W-1:0]     head_data;
  logic                  head_last;
  logic                  pop;
  logic [1:0]            occ;

  assign wr_rdy = (bank_st[wr_bank] == BANK_EMPTY);
  assign pop    = fifo_vld & out_rdy;
  // A pop this cycle frees a slot in time for a read issued now.
  assign occ      = fifo_cnt + {1'b0, vld_p1} - {1'b0, pop};
  assign issue_p0 = (rd_st == RD_DRAIN) && !issue_done_p0 && (occ < CREDIT_MAX);

  assign mem_rd_en = issue_p0;
  assign mem_rbank = rd_bank;
  assign mem_raddr = rd_addr_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_st[0]    <= BANK_EMPTY;
      bank_st[1]    <= BANK_EMPTY;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      rd_st         <= RD_IDLE;
      rd_addr_p0    <= '0;
      issue_done_p0 <= 1'b0;
      vld_p1        <= 1'b0;
    end else begin
      vld_p1 <= issue_p0;
      if (wr_done && wr_rdy) begin
        bank_st[wr_bank] <= BANK_FULL;
        wr_bank          <= ~wr_bank;
      end
      case (rd_st)
        RD_IDLE: begin
          if (bank_st[rd_bank] == BANK_FULL) begin
            bank_st[rd_bank] <= BANK_DRAIN;
            rd_st            <= RD_DRAIN;
            rd_addr_p0       <= '0;
            issue_done_p0    <= 1'b0;
          end
        end
        RD_DRAIN: begin
          if (issue_p0) begin
            if (rd_addr_p0 == len_p0 || rd_addr_p0 == ADDR_MAX) issue_done_p0 <= 1'b1;
            else rd_addr_p0 <= rd_addr_p0 + 1'b1;
          end
          // Release is written last so it wins over any same-edge bank update.
          if (pop && head_last) begin
            bank_st[rd_bank] <= BANK_EMPTY;
            rd_bank          <= ~rd_bank;
            rd_st            <= RD_IDLE;
          end
        end
        default: rd_st <= RD_IDLE;
      endcase
    end
  end

  // Stage p0 -> p1: read issue captured with its end-of-bank tag.
  always_ff @(posedge clk) begin
    if (rd_st == RD_IDLE && bank_st[rd_bank] == BANK_FULL) len_p0 <= num_of_dat;
    last_p1 <= (rd_addr_p0 == len_p0);
  end

  tt_pp_out_fifo #(.DATA_W(DATA_W)) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (vld_p1),
    .push_data (mem_rdata),
    .push_last (last_p1),
    .pop       (pop),
    .count     (fifo_cnt),
    .vld       (fifo_vld),
    .head_data (head_data),
    .head_last (head_last)
  );

  assign out_vld  = fifo_vld;
  assign out_data = fifo_vld ? head_data : '0;
  assign out_last = fifo_vld & head_last;
  assign busy     = (bank_st[0] != BANK_EMPTY) || (bank_st[1] != BANK_EMPTY) ||
                    fifo_vld || vld_p1;

`ifdef TT_PP_OVF_CHECK_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else if (wr_done && !wr_rdy) ovf_q <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(wr_done && !wr_rdy))
      else $warning("wr_done received while both banks are occupied");
  end

  assign ovf_err = ovf_q;
`else
  assign ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_tt_pingpong_rd_ctrl.sv
// Directed self-checking bench for tt_pingpong_rd_ctrl with a 1-cycle SRAM model.
module tb_tt_pingpong_rd_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_done;
  logic        wr_bank;
  logic        wr_rdy;
  logic [3:0]  num_of_dat;
  logic        mem_rd_en;
  logic        mem_rbank;
  logic [3:0]  mem_raddr;
  logic [63:0] mem_rdata = '0;
  logic        out_vld;
  logic        out_rdy;
  logic [63:0] out_data;
  logic        out_last;
  logic        busy;
  logic        ovf_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic exp_ovf;

  logic [64:0] beats[$];
  int          beat_t[$];
  logic [4:0]  rds[$];
  logic        stall_prev = 1'b0;
  logic [64:0] stall_word;

  tt_pingpong_rd_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .wr_done    (wr_done),
    .wr_bank    (wr_bank),
    .wr_rdy     (wr_rdy),
    .num_of_dat (num_of_dat),
    .mem_rd_en  (mem_rd_en),
    .mem_rbank  (mem_rbank),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .out_vld    (out_vld),
    .out_rdy    (out_rdy),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .ovf_err    (ovf_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [63:0] word(input logic b, input logic [3:0] a);
    return {16'hC0DE, 8'h00, 7'h00, b, 12'h000, a, 16'h5A00 | 16'({12'h0, a} * 3 + {15'h0, b} * 7)};
  endfunction

  always @(posedge clk) if (mem_rd_en) mem_rdata <= word(mem_rbank, mem_raddr);

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) stall_prev = 1'b0;
    else begin
      if (stall_prev) chk("stall_hold", {out_last, out_data}, stall_word);
      if (mem_rd_en) rds.push_back({mem_rbank, mem_raddr});
      if (out_vld && out_rdy) begin
        beats.push_back({out_last, out_data});
        beat_t.push_back(cyc);
      end
      stall_prev = out_vld && !out_rdy;
      stall_word = {out_last, out_data};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    beats.delete();
    beat_t.delete();
    rds.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_rdy"}, 65'(wr_rdy), 65'd1);
    chk({tag, "_wr_bank"}, 65'(wr_bank), 65'd0);
    chk({tag, "_rd_en"}, 65'(mem_rd_en), 65'd0);
    chk({tag, "_vld"}, 65'(out_vld), 65'd0);
    chk({tag, "_last"}, 65'(out_last), 65'd0);
    chk({tag, "_data"}, 65'(out_data), 65'd0);
    chk({tag, "_busy"}, 65'(busy), 65'd0);
    chk({tag, "_ovf"}, 65'(ovf_err), 65'd0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    wr_done = 1'b0;
    tick();
    tick();
    check_reset_outputs(tag);
    rst = 1'b0;
    clear_q();
    tick();
  endtask

  task automatic pulse_wr();
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
  endtask

  task automatic wait_beats(input string tag, input int n, input int budget, input bit rnd);
    for (int i = 0; i < budget && beats.size() < n; i++) begin
      if (rnd) out_rdy = 1'($urandom_range(0, 1));
      tick();
    end
    chk({tag, "_beat_count"}, 65'(beats.size()), 65'(n));
  endtask

  task automatic check_seq(input string tag, input int n, input logic [3:0] len);
    for (int i = 0; i < n && i < beats.size(); i++) begin
      logic       b;
      logic [3:0] a;
      b = 1'((i / (int'(len) + 1)) % 2);
      a = 4'(i % (int'(len) + 1));
      chk({tag, "_beat"}, beats[i], {a == len, word(b, a)});
    end
    chk({tag, "_rd_count"}, 65'(rds.size()), 65'(n));
    for (int i = 0; i < n && i < rds.size(); i++)
      chk({tag, "_rd_addr"}, 65'(rds[i]),
          65'({1'((i / (int'(len) + 1)) % 2), 4'(i % (int'(len) + 1))}));
  endtask

  initial begin
`ifdef TT_PP_OVF_CHECK_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    rst = 1'b1;
    wr_done = 1'b0;
    out_rdy = 1'b0;
    num_of_dat = 4'd3;
    tick();
    do_reset("rst0");

    // Single bank, 4 words; a later num_of_dat change must not shorten it.
    out_rdy = 1'b1;
    while (cyc < 10) tick();
    pulse_wr();
    chk("t1_wr_bank", 65'(wr_bank), 65'd1);
    chk("t1_busy_on", 65'(busy), 65'd1);
    tick();
    num_of_dat = 4'd0;
    wait_beats("t1", 4, 40, 1'b0);
    chk("t1_wr_rdy", 65'(wr_rdy), 65'd1);
    chk("t1_busy_off", 65'(busy), 65'd0);
    check_seq("t1", 4, 4'd3);
    if (beat_t.size() == 4) chk("t1_burst", 65'(beat_t[3] - beat_t[0]), 65'd3);
    tick();
    tick();
    chk("t1_no_more", 65'(beats.size()), 65'd4);

    // Back-to-back banks under back-pressure.
    num_of_dat = 4'd3;
    out_rdy = 1'b0;
    do_reset("rst2");
    pulse_wr();
    pulse_wr();
    chk("t2_wr_rdy_low", 65'(wr_rdy), 65'd0);
    for (int i = 0; i < 10; i++) tick();
    chk("t2_rd_buffered", 65'(rds.size()), 65'd2);
    chk("t2_no_beats", 65'(beats.size()), 65'd0);
    chk("t2_head_vld", 65'(out_vld), 65'd1);
    chk("t2_head_data", 65'(out_data), 65'(word(1'b0, 4'd0)));
    out_rdy = 1'b1;
    wait_beats("t2a", 4, 40, 1'b0);
    chk("t2_wr_rdy_back", 65'(wr_rdy), 65'd1);
    wait_beats("t2b", 8, 40, 1'b0);
    check_seq("t2", 8, 4'd3);
    chk("t2_busy_off", 65'(busy), 65'd0);

    // Full 16-word banks with random stalls.
    num_of_dat = 4'd15;
    do_reset("rst3");
    pulse_wr();
    pulse_wr();
    wait_beats("t3", 32, 2000, 1'b1);
    out_rdy = 1'b1;
    tick();
    tick();
    check_seq("t3", 32, 4'd15);

    // Single-word banks.
    num_of_dat = 4'd0;
    do_reset("rst4");
    pulse_wr();
    pulse_wr();
    wait_beats("t4", 2, 40, 1'b0);
    check_seq("t4", 2, 4'd0);
    chk("t4_wr_rdy", 65'(wr_rdy), 65'd1);

    // Reset mid-drain, then restart from bank 0 address 0.
    num_of_dat = 4'd15;
    do_reset("rst5");
    pulse_wr();
    wait_beats("t5a", 5, 40, 1'b0);
    rst = 1'b1;
    tick();
    check_reset_outputs("t5_mid");
    rst = 1'b0;
    clear_q();
    num_of_dat = 4'd2;
    tick();
    pulse_wr();
    wait_beats("t5b", 3, 40, 1'b0);
    check_seq("t5", 3, 4'd2);

    // Third wr_done with both banks occupied.
    num_of_dat = 4'd3;
    out_rdy = 1'b0;
    do_reset("rst6");
    pulse_wr();
    pulse_wr();
    pulse_wr();
    chk("t6_wr_bank", 65'(wr_bank), 65'd0);
    chk("t6_wr_rdy", 65'(wr_rdy), 65'd0);
    chk("t6_ovf", 65'(ovf_err), 65'(exp_ovf));
    for (int i = 0; i < 5; i++) tick();
    chk("t6_ovf_sticky", 65'(ovf_err), 65'(exp_ovf));
    out_rdy = 1'b1;
    wait_beats("t6", 8, 60, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    chk("t6_total_beats", 65'(beats.size()), 65'd8);
    check_seq("t6", 8, 4'd3);
    chk("t6_ovf_end", 65'(ovf_err), 65'(exp_ovf));
    chk("t6_idle", 65'(busy), 65'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
